// File: rtl/midi_pkg.sv
`default_nettype none
// ============================================================================
// Module : midi_pkg
// Desc   : Shared MIDI constants, FSM state type and status-byte helper.
// Rev    : 1.0
// ============================================================================
package midi_pkg;

  localparam logic [3:0] MIDI_NOTE_ON          = 4'h9;
  localparam logic [3:0] MIDI_NOTE_OFF         = 4'h8;
  localparam int         MIDI_BAUD_TICKS_12MHZ = 384;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_SEND_STATUS = 2'd1,
    ST_SEND_NOTE   = 2'd2,
    ST_SEND_VEL    = 2'd3
  } midi_state_t;

  function automatic logic [7:0] midi_status(input logic note_on, input logic [3:0] channel);
    return {note_on ? MIDI_NOTE_ON : MIDI_NOTE_OFF, channel};
  endfunction

endpackage
`default_nettype wire

// File: rtl/midi_uart_byte_tx.sv
`default_nettype none
// ============================================================================
// Module : midi_uart_byte_tx
// Desc   : 8N1 LSB-first byte serializer; accepts a new byte in its done cycle.
// Rev    : 1.0
// ============================================================================
module midi_uart_byte_tx
  import midi_pkg::*;
#(
  parameter int BIT_TICKS = MIDI_BAUD_TICKS_12MHZ
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done,
  output logic       busy
);

  localparam int            TW          = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam logic [TW-1:0] c_last_tick = TW'(BIT_TICKS - 1);
  localparam logic [3:0]    c_stop_bit  = 4'd9;

  logic [TW-1:0] r_tick;
  logic [3:0]    r_bit;
  logic [8:0]    r_shift;
  logic          r_tx;
  logic          r_busy;
  logic          w_bit_end;

  assign w_bit_end = (r_tick == c_last_tick);
  assign done      = r_busy && w_bit_end && (r_bit == c_stop_bit);
  assign tx        = r_tx;
  assign busy      = r_busy;

  // r_shift holds the bits still to go out after the start bit; a 1 is
  // shifted in behind the data so the stop bit falls out naturally.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '1;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else if (start && (!r_busy || done)) begin
      r_tx    <= 1'b0;
      r_shift <= {1'b1, data};
      r_tick  <= '0;
      r_bit   <= '0;
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      if (w_bit_end) begin
        r_tick <= '0;
        if (r_bit == c_stop_bit) begin
          r_busy <= 1'b0;
          r_tx   <= 1'b1;
          r_bit  <= '0;
        end else begin
          r_tx    <= r_shift[0];
          r_shift <= {1'b1, r_shift[8:1]};
          r_bit   <= r_bit + 4'd1;
        end
      end else begin
        r_tick <= r_tick + TW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/midi_tx.sv
`default_nettype none
// ============================================================================
// Module : midi_tx
// Desc   : MIDI note-on/off transmitter with optional running status.
// Rev    : 1.0
// ============================================================================
module midi_tx
  import midi_pkg::*;
#(
  parameter int BIT_TICKS            = MIDI_BAUD_TICKS_12MHZ,
  parameter int RUNNING_STATUS       = 1,
  parameter int NOTE_OFF_AS_ZERO_VEL = 0
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic       ev_note_on,
  input  logic [3:0] ev_channel,
  input  logic [6:0] ev_note,
  input  logic [6:0] ev_velocity,
  output logic       tx,
  output logic       busy
);

  localparam logic c_running  = (RUNNING_STATUS != 0);
  localparam logic c_zero_vel = (NOTE_OFF_AS_ZERO_VEL != 0);

  midi_state_t r_state;
  logic [7:0]  r_note_byte;
  logic [7:0]  r_vel_byte;
  logic [7:0]  r_last_status;
  logic        r_last_valid;

  logic        w_accept;
  logic        w_skip_status;
  logic [7:0]  w_status;
  logic [7:0]  w_vel_byte;
  logic        w_start;
  logic [7:0]  w_byte;
  logic        w_done;
  logic        w_ser_busy;

  assign w_status      = midi_status(ev_note_on || c_zero_vel, ev_channel);
  assign w_vel_byte    = (!ev_note_on && c_zero_vel) ? 8'h00 : {1'b0, ev_velocity};
  assign w_accept      = ev_valid && ev_ready;
  assign w_skip_status = c_running && r_last_valid && (w_status == r_last_status);

  // The serializer is busy exactly while a message is in flight.
  assign ev_ready = !w_ser_busy;
  assign busy     = w_ser_busy;

  // Next byte is launched in the done cycle of the previous one so bytes abut.
  always_comb begin
    w_start = 1'b0;
    w_byte  = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_start = 1'b1;
          w_byte  = w_skip_status ? {1'b0, ev_note} : w_status;
        end
      end
      ST_SEND_STATUS: begin
        if (w_done) begin
          w_start = 1'b1;
          w_byte  = r_note_byte;
        end
      end
      ST_SEND_NOTE: begin
        if (w_done) begin
          w_start = 1'b1;
          w_byte  = r_vel_byte;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_state       <= ST_IDLE;
      r_note_byte   <= 8'h00;
      r_vel_byte    <= 8'h00;
      r_last_status <= 8'h00;
      r_last_valid  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_note_byte <= {1'b0, ev_note};
            r_vel_byte  <= w_vel_byte;
            if (w_skip_status) begin
              r_state <= ST_SEND_NOTE;
            end else begin
              r_state       <= ST_SEND_STATUS;
              r_last_status <= w_status;
              r_last_valid  <= 1'b1;
            end
          end
        end
        ST_SEND_STATUS: if (w_done) r_state <= ST_SEND_NOTE;
        ST_SEND_NOTE:   if (w_done) r_state <= ST_SEND_VEL;
        ST_SEND_VEL:    if (w_done) r_state <= ST_IDLE;
        default:        r_state <= ST_IDLE;
      endcase
    end
  end

  midi_uart_byte_tx #(
    .BIT_TICKS(BIT_TICKS)
  ) u_ser (
    .clk   (clk),
    .resetq(resetq),
    .start (w_start),
    .data  (w_byte),
    .tx    (tx),
    .done  (w_done),
    .busy  (w_ser_busy)
  );

endmodule
`default_nettype wire

// File: doc/midi_tx.md
# midi_tx

MIDI note transmitter, the outbound counterpart of the note-on receive path in `top`. Accepts note events over a valid/ready handshake, formats them as MIDI channel voice messages (status, note, velocity), and serializes them on a single UART line at MIDI rate (8N1, LSB first). Optionally suppresses repeated status bytes (running status). Sits between a sequencer or loopback source and the board `tx` pin.

## Interface

- `BIT_TICKS`, 384: clock cycles per bit (12 MHz / 31250 baud); must be ≥ 2.
- `RUNNING_STATUS`, 1: 1 = omit the status byte when it equals the last status sent.
- `NOTE_OFF_AS_ZERO_VEL`, 0: 1 = encode note-off as status 0x9n with velocity 0x00.
- `clk`  in  1  system clock.
- `resetq`  in  1  reset; one clock; reset is asynchronous and active-low.
- `ev_valid`  in  1  event offered.
- `ev_ready`  out  1  block can accept an event.
- `ev_note_on`  in  1  1 = note-on (0x9n), 0 = note-off (0x8n).
- `ev_channel`  in  4  MIDI channel n.
- `ev_note`  in  7  note number.
- `ev_velocity`  in  7  velocity.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  message in flight (equal to `!ev_ready`).

## Operation

- Accept when `ev_valid && ev_ready` on a rising `clk`; capture all `ev_*` fields. Inputs are ignored when not accepted.
- Status byte = {1, note_on ? 3'b001 : 3'b000, channel}. If `NOTE_OFF_AS_ZERO_VEL` and note-off, status = 0x9n and the velocity byte is 0x00.
- Data bytes = {0, ev_note}, {0, velocity}; MSB is always 0.
- FSM states: IDLE → SEND_STATUS → SEND_NOTE → SEND_VEL → IDLE.
  - From IDLE on accept: go to SEND_NOTE if `RUNNING_STATUS` and `last_valid` and the status equals `last_status`; otherwise go to SEND_STATUS.
  - Each SEND state leaves when its byte's stop bit completes.
- `last_status`/`last_valid` update on entry to SEND_STATUS. They are cleared by reset.
- Frame per byte: start bit (0), 8 data bits LSB first, stop bit (1). Each bit is held exactly `BIT_TICKS` cycles.

## Timing

- Reset values: `tx`=1, `ev_ready`=1, `busy`=0, state IDLE, `last_valid`=0, bit and tick counters 0.
- Accept in cycle k: `ev_ready` is 0 from k+1, and the start bit is on `tx` from k+1.
- Bytes within a message are back-to-back: the next start bit follows the previous stop bit with no idle cycle.
- Full message: 30·`BIT_TICKS` cycles. Running-status message: 20·`BIT_TICKS` cycles.
- `ev_ready` returns to 1 in the first cycle after the last stop bit completes. With `ev_valid` held, consecutive messages have exactly 1 idle-high cycle between them.
- An event held with `ev_valid` while busy stays pending. It is not captured and no data changes.
- Reset mid-frame: `tx` goes to 1 asynchronously and the FSM aborts. The next event always sends a status byte.
- Tick counter width is clog2(`BIT_TICKS`) and wraps at `BIT_TICKS`−1. Bit counter runs 0..9.

## Structure

- Package `midi_pkg`:
  - status nibble constants `MIDI_NOTE_ON`=4'h9 and `MIDI_NOTE_OFF`=4'h8;
  - `MIDI_BAUD_TICKS_12MHZ`=384;
  - FSM state typedef.
- Sub-module `midi_uart_byte_tx`, the byte serializer:
  - ports `start`, `data[7:0]`, `tx`, `done` (1-cycle pulse at end of stop bit), `busy`;
  - parameter `BIT_TICKS`.
- `midi_tx` holds the handshake, the formatting, running status and the FSM. It issues `start` with the next byte in the same cycle as `done`, to keep bytes back-to-back.

## Test plan

- Reset, then idle for 1000 cycles → `tx`=1, `ev_ready`=1, `busy`=0 throughout.
- Note-on ch0, note 60, vel 100 → `tx` shows 0x90, 0x3C, 0x64, each LSB first; the message lasts 11520 cycles; `ev_ready` is back to 1 at cycle 11521.
- Same event repeated with note 62 and `RUNNING_STATUS`=1 → only 0x3E, 0x64 are sent (7680 cycles). With `RUNNING_STATUS`=0 → 0x90, 0x3E, 0x64.
- Note-off ch3, note 64, vel 40 → 0x83, 0x40, 0x28. With `NOTE_OFF_AS_ZERO_VEL`=1 → 0x93, 0x40, 0x00.
- `ev_valid` held with changing fields while busy → no capture; the queued event goes out with 1 idle cycle after the prior stop bit.
- `resetq` pulsed low mid-note byte, then the same note-on as before is sent → `tx` is 1 immediately; the full 0x90 status is resent.
